// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction memory as big-endian 32-bit words,
// written sequentially from word 0, and holds the CPU until the image is loaded.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   start                 one-cycle pulse that begins or restarts a load
//   ld_valid/ld_data/ld_last/ld_ready   byte stream handshake (ld_last marks final byte)
//   imem_we/imem_addr/imem_wdata        instruction memory write port (byte address)
//   prog_size             number of words written
//   load_done / load_err  image complete / image exceeded 2**ADDR_W words
//   checksum              wrapping sum of written words (IMEM_LOADER_CHECKSUM_EN), else 0
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [31:0] prog_size,
    output logic        load_done,
    output logic        load_err,
    output logic [31:0] checksum
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned WCNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    logic [2:0]        state_q, state_n;
    logic [1:0]        byte_cnt_q, byte_cnt_n;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_n;
    logic [31:0]       shift_q, shift_n;
    logic              last_q, last_n;

    logic              ld_ready_n, imem_we_n, load_done_n, load_err_n;
    logic [31:0]       imem_addr_n, imem_wdata_n, prog_size_n;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q, csum_n;
    assign checksum = csum_q;
`else
    assign checksum = 32'd0;
`endif

    // State and registered outputs; reset drops imem_we without waiting for a clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            shift_q    <= 32'd0;
            last_q     <= 1'b0;
            ld_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            prog_size  <= 32'd0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_n;
            byte_cnt_q <= byte_cnt_n;
            word_cnt_q <= word_cnt_n;
            shift_q    <= shift_n;
            last_q     <= last_n;
            ld_ready   <= ld_ready_n;
            imem_we    <= imem_we_n;
            imem_addr  <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            prog_size  <= prog_size_n;
            load_done  <= load_done_n;
            load_err   <= load_err_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_n;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state_q;
        byte_cnt_n   = byte_cnt_q;
        word_cnt_n   = word_cnt_q;
        shift_n      = shift_q;
        last_n       = last_q;
        ld_ready_n   = ld_ready;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        prog_size_n  = prog_size;
        load_done_n  = load_done;
        load_err_n   = load_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_n       = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_n     = S_COLLECT;
                    byte_cnt_n  = 2'd0;
                    word_cnt_n  = '0;
                    shift_n     = 32'd0;
                    last_n      = 1'b0;
                    prog_size_n = 32'd0;
                    load_done_n = 1'b0;
                    load_err_n  = 1'b0;
                    ld_ready_n  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_n      = 32'd0;
`endif
                end
            end

            S_COLLECT: begin
                if (ld_valid && ld_ready) begin
                    // First byte clears the low bytes so a short final word is zero-padded
                    case (byte_cnt_q)
                        2'd0:    shift_n        = {ld_data, 24'h0};
                        2'd1:    shift_n[23:16] = ld_data;
                        2'd2:    shift_n[15:8]  = ld_data;
                        default: shift_n[7:0]   = ld_data;
                    endcase
                    byte_cnt_n = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3 || ld_last) begin
                        state_n      = S_WRITE;
                        last_n       = ld_last;
                        ld_ready_n   = 1'b0;
                        imem_we_n    = 1'b1;
                        imem_addr_n  = 32'(word_cnt_q) << 2;
                        imem_wdata_n = shift_n;
                    end
                end
            end

            S_WRITE: begin
                word_cnt_n  = word_cnt_q + WCNT_W'(1);
                prog_size_n = 32'(word_cnt_q) + 32'd1;
                byte_cnt_n  = 2'd0;
                shift_n     = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_n      = csum_q + shift_q;
`endif
                if (last_q) begin
                    state_n     = S_DONE;
                    load_done_n = 1'b1;
                end else if (word_cnt_q == WCNT_W'(DEPTH - 1)) begin
                    state_n    = S_ERROR;
                    load_err_n = 1'b1;
                end else begin
                    state_n    = S_COLLECT;
                    ld_ready_n = 1'b1;
                end
            end

            default: begin
                state_n    = S_IDLE;
                ld_ready_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance and an ADDR_W=2
// instance share the stimulus; the small one exercises the overflow path.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, ld_valid, ld_last;
    logic [7:0]  ld_data;

    logic        ld_ready, imem_we, load_done, load_err;
    logic [31:0] imem_addr, imem_wdata, prog_size, checksum;

    logic        ld_ready_b, imem_we_b, load_done_b, load_err_b;
    logic [31:0] imem_addr_b, imem_wdata_b, prog_size_b, checksum_b;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wa [0:63];
    logic [31:0] wd [0:63];
    int          wcount = 0;
    logic [31:0] wa_b [0:63];
    logic [31:0] wd_b [0:63];
    int          wcount_b = 0;

    imem_loader dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .prog_size(prog_size), .load_done(load_done), .load_err(load_err), .checksum(checksum)
    );

    imem_loader #(.ADDR_W(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_b),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .prog_size(prog_size_b), .load_done(load_done_b), .load_err(load_err_b),
        .checksum(checksum_b)
    );

    always #5 clock = ~clock;

    // Write logger, sampled mid-cycle
    always @(negedge clock) begin
        if (imem_we) begin
            wa[wcount % 64] <= imem_addr;
            wd[wcount % 64] <= imem_wdata;
            wcount <= wcount + 1;
        end
        if (imem_we_b) begin
            wa_b[wcount_b % 64] <= imem_addr_b;
            wd_b[wcount_b % 64] <= imem_wdata_b;
            wcount_b <= wcount_b + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        while (!ld_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!ld_ready) begin
            check("ready_timeout", 32'(ld_ready), 32'd1);
        end else begin
            ld_valid = 1'b1;
            ld_data  = d;
            ld_last  = l;
            @(negedge clock);
            ld_valid = 1'b0;
            ld_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!load_done && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("load_done", 32'(load_done), 32'd1);
    endtask

    task automatic send_prog1(input logic with_gap);
        logic [7:0] b [0:7];
        b[0] = 8'h20; b[1] = 8'h08; b[2] = 8'h00; b[3] = 8'h05;
        b[4] = 8'h01; b[5] = 8'h09; b[6] = 8'h50; b[7] = 8'h20;
        for (int i = 0; i < 8; i++) begin
            if (with_gap && i == 2) begin
                for (int g = 0; g < 3; g++) begin
                    check("gap_ready", 32'(ld_ready), 32'd1);
                    check("gap_no_we", 32'(imem_we), 32'd0);
                    @(negedge clock);
                end
            end
            send_byte(b[i], i == 7);
        end
    endtask

    int base;
    int base_b;
    logic [31:0] exp_cs;

    initial begin
        reset_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
        do_reset();

        // Reset state
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_size", prog_size, 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_csum", checksum, 32'd0);

        // Two full words
        base = wcount;
        pulse_start();
        check("coll_ready", 32'(ld_ready), 32'd1);
        send_prog1(1'b0);
        wait_done();
        check("p1_nwr", 32'(wcount - base), 32'd2);
        check("p1_a0", wa[base % 64], 32'h0);
        check("p1_d0", wd[base % 64], 32'h20080005);
        check("p1_a1", wa[(base + 1) % 64], 32'h4);
        check("p1_d1", wd[(base + 1) % 64], 32'h01095020);
        check("p1_size", prog_size, 32'd2);
        check("p1_done_ready", 32'(ld_ready), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_cs = 32'h21115025;
`else
        exp_cs = 32'h0;
`endif
        check("p1_csum", checksum, exp_cs);
        check("p1_b_done", 32'(load_done_b), 32'd1);
        check("p1_b_csum", checksum_b, exp_cs);

        // Restart from DONE with a padded final word
        base = wcount;
        pulse_start();
        check("rs_done_clr", 32'(load_done), 32'd0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1);
        wait_done();
        check("p2_nwr", 32'(wcount - base), 32'd2);
        check("p2_d0", wd[base % 64], 32'hAABBCCDD);
        check("p2_a1", wa[(base + 1) % 64], 32'h4);
        check("p2_d1", wd[(base + 1) % 64], 32'h11220000);
        check("p2_size", prog_size, 32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_cs = 32'hBBDDCCDD;
`else
        exp_cs = 32'h0;
`endif
        check("p2_csum", checksum, exp_cs);

        // Stalled stream produces the same image
        base = wcount;
        pulse_start();
        send_prog1(1'b1);
        wait_done();
        check("gap_nwr", 32'(wcount - base), 32'd2);
        check("gap_d0", wd[base % 64], 32'h20080005);
        check("gap_d1", wd[(base + 1) % 64], 32'h01095020);

        // Overflow on the ADDR_W=2 instance
        base_b = wcount_b;
        pulse_start();
        for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
        repeat (3) @(negedge clock);
        check("ov_nwr", 32'(wcount_b - base_b), 32'd4);
        check("ov_a0", wa_b[base_b % 64], 32'h0);
        check("ov_a1", wa_b[(base_b + 1) % 64], 32'h4);
        check("ov_a2", wa_b[(base_b + 2) % 64], 32'h8);
        check("ov_a3", wa_b[(base_b + 3) % 64], 32'hC);
        check("ov_d3", wd_b[(base_b + 3) % 64], 32'h0C0D0E0F);
        check("ov_err", 32'(load_err_b), 32'd1);
        check("ov_ready", 32'(ld_ready_b), 32'd0);
        check("ov_size", prog_size_b, 32'd4);

        // Asynchronous reset during the write of word 1
        do_reset();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1'b0);
        check("ar_we_before", 32'(imem_we), 32'd1);
        check("ar_addr_before", imem_addr, 32'h4);
        #2 reset_n = 1'b0;
        #1;
        check("ar_we", 32'(imem_we), 32'd0);
        check("ar_addr", imem_addr, 32'd0);
        check("ar_wdata", imem_wdata, 32'd0);
        check("ar_size", prog_size, 32'd0);
        check("ar_ready", 32'(ld_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        base = wcount;
        pulse_start();
        send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b1);
        wait_done();
        check("ar_nwr", 32'(wcount - base), 32'd1);
        check("ar_a0", wa[base % 64], 32'h0);
        check("ar_d0", wd[base % 64], 32'hDEADBEEF);
        check("ar_size1", prog_size, 32'd1);

        // Reload after DONE
        base = wcount;
        pulse_start();
        check("rl_done_clr", 32'(load_done), 32'd0);
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b1);
        wait_done();
        check("rl_a0", wa[base % 64], 32'h0);
        check("rl_d0", wd[base % 64], 32'h12345678);
        check("rl_size", prog_size, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_cs = 32'h12345678;
`else
        exp_cs = 32'h0;
`endif
        check("rl_csum", checksum, exp_cs);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction image consumed by the PC/fetch path.
- Accepts a byte stream, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory from word 0.
- Reports the program size in words and holds the CPU until loading completes.
- The PC compares against `prog_size` for end-of-program, so the file-scan size calculation is no longer needed.

Parameters:
- `ADDR_W`, default 10: instruction memory word-address width; capacity is `DEPTH = 2**ADDR_W` words.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins or restarts a load.
- `ld_valid`  in  1  byte valid.
- `ld_data`  in  8  byte value.
- `ld_last`  in  1  marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  32  byte address, word-aligned: `word_cnt*4`.
- `imem_wdata`  out  32  assembled instruction word.
- `prog_size`  out  32  number of words written, zero-extended.
- `load_done`  out  1  image fully written; CPU may run.
- `load_err`  out  1  image exceeded `DEPTH`.
- `checksum`  out  32  see Optional Feature.

Behaviour:
- Reset (`reset_n`=0, asynchronous):
  - State = IDLE.
  - All outputs 0.
  - `byte_cnt`, `word_cnt`, shift register and `last_flag` cleared.
  - Asserting reset mid-load aborts it; `imem_we` drops immediately.
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE:
  - `ld_ready`=0.
  - `start` → COLLECT; `byte_cnt`=0, `word_cnt`=0, `prog_size`=0.
- COLLECT:
  - `ld_ready`=1.
  - Handshake: a byte transfers when `ld_valid` && `ld_ready` on a rising edge.
  - Byte k (0..3) of a word lands in bits [31-8k : 24-8k]; first byte → MSB.
  - On the 4th byte → WRITE.
  - On `ld_last` with fewer than 4 bytes: unfilled low bytes are zero-padded, `last_flag` is set → WRITE.
  - `ld_last` on the 4th byte also sets `last_flag`.
- WRITE (exactly 1 cycle):
  - `ld_ready`=0, `imem_we`=1, `imem_addr`=`word_cnt<<2`, `imem_wdata`=assembled word.
  - Next edge: `word_cnt`++, `prog_size`=`word_cnt`+1, `byte_cnt`=0.
  - If `last_flag` → DONE.
  - Else, if `word_cnt` was `DEPTH-1` → ERROR.
  - Else → COLLECT.
- DONE:
  - `load_done`=1, `ld_ready`=0, `prog_size` held.
  - `start` → COLLECT and clears `load_done`.
- ERROR:
  - `load_err`=1, `ld_ready`=0; `prog_size`=`DEPTH` held.
  - `start` → COLLECT and clears `load_err`.
- `start` in COLLECT or WRITE is ignored.
- Throughput: minimum 5 cycles per word (4 accept cycles + 1 write cycle). Back-to-back `ld_valid` is allowed.
- `imem_we` is never asserted outside WRITE. Addresses are strictly sequential and never wrap.
- `word_cnt` is `ADDR_W+1` bits wide so that `DEPTH` is representable.

Optional Feature:
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - `checksum` = 32-bit wrapping sum of every word written (after padding).
  - Cleared on reset and on an accepted `start`.
  - Updated on the edge ending WRITE; valid when `load_done`=1.
- Undefined: `checksum` is tied to 0 and no adder is built.

Test Plan:
- Reset, `start`, stream 8 bytes 0x20,0x08,0x00,0x05,0x01,0x09,0x50,0x20 with `ld_last` on the 8th.
  - Two writes: addr 0x0 ← 0x20080005, then addr 0x4 ← 0x01095020.
  - `load_done`=1, `prog_size`=2.
  - `checksum`=0x21115025 when the macro is defined.
- Stream 6 bytes AA,BB,CC,DD,11,22 with `ld_last` on 22.
  - Second write is addr 0x4 ← 0x11220000.
  - `prog_size`=2.
- Deassert `ld_valid` for 3 cycles between bytes 2 and 3.
  - No write occurs early; `ld_ready` stays 1.
  - Written word is unchanged versus the contiguous stream.
- With `ADDR_W`=2, stream 20 bytes and no `ld_last`.
  - Writes go to addr 0x0, 0x4, 0x8, 0xC.
  - Then `load_err`=1, `ld_ready`=0, `prog_size`=4, and no fifth write.
- Pull `reset_n` low during WRITE of word 1.
  - `imem_we` falls with no clock edge; all outputs 0; state IDLE.
  - A subsequent `start` plus a 4-byte image gives `prog_size`=1 at addr 0x0.
- After DONE, pulse `start` and load 4 new bytes.
  - `load_done` clears on the next edge.
  - Rewrite is at addr 0x0; `prog_size`=1.
